// File: rtl/case1_vector_sequencer_if.sv
// case1_vector_sequencer_if: valid/ready stream carrying (A,B) test vectors
//   vec_valid  source has a vector
//   vec_a/b    vector bits
//   vec_ready  sequencer accepts the vector this cycle
interface case1_vector_sequencer_if;
    logic vec_valid;
    logic vec_a;
    logic vec_b;
    logic vec_ready;
    modport master (output vec_valid, vec_a, vec_b, input vec_ready);
    modport slave  (input vec_valid, vec_a, vec_b, output vec_ready);
endinterface

// File: rtl/case1_vector_sequencer.sv
// case1_vector_sequencer: drives (A,B) vectors into the Case1 path and checks Y = ~(A^B) after LATENCY cycles
//   clk, rst_n      clock shared with the datapath; async active-low reset
//   start, num_vec  begin a run of num_vec vectors (sampled in IDLE only)
//   vec             vector stream (slave side)
//   dut_a, dut_b    registered drive into the datapath
//   dut_y           datapath output
//   busy, done      run in progress; one-cycle end-of-run pulse
//   pass_cnt, fail_cnt, fail_seen, first_fail_idx  saturating run results
module case1_vector_sequencer #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_vec,
    case1_vector_sequencer_if.slave vec,
    output logic                 dut_a,
    output logic                 dut_b,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 fail_seen,
    output logic [CNT_W-1:0]     first_fail_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t state, state_nx;
    logic [CNT_W-1:0] nv, acc_cnt;
    // check pipeline: valid, expected Y and acceptance index per stage; stage LATENCY lines up with dut_y
    logic [LATENCY:0] pv, pe;
    logic [CNT_W-1:0] pidx [LATENCY+1];
    logic ready, accept, chk, mis, clr;
    assign vec.vec_ready = ready;
    assign accept = vec.vec_valid & ready;
    assign chk = pv[LATENCY];
    assign mis = chk & (dut_y != pe[LATENCY]);
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        ready = 1'b0;
        clr = 1'b0;
        case (state)
            IDLE: begin
                clr = start;
                state_nx = !start ? IDLE : (num_vec == '0 ? DONE : RUN);
            end
            RUN: begin
                ready = acc_cnt < nv;
                state_nx = (accept && acc_cnt == nv - 1'b1) ? DRAIN : RUN;
            end
            DRAIN: state_nx = pv == '0 ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            nv <= '0;
            acc_cnt <= '0;
            pv <= '0;
            pe <= '0;
            for (int i = 0; i <= LATENCY; i++) pidx[i] <= '0;
            dut_a <= 1'b0;
            dut_b <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            fail_seen <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            state <= state_nx;
            pv <= {pv[LATENCY-1:0], accept};
            pe <= {pe[LATENCY-1:0], ~(vec.vec_a ^ vec.vec_b)};
            pidx[0] <= acc_cnt;
            for (int i = 1; i <= LATENCY; i++) pidx[i] <= pidx[i-1];
            if (accept) begin
                dut_a <= vec.vec_a;
                dut_b <= vec.vec_b;
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (clr) begin
                nv <= num_vec;
                acc_cnt <= '0;
                pass_cnt <= '0;
                fail_cnt <= '0;
                fail_seen <= 1'b0;
                first_fail_idx <= '0;
            end else if (chk) begin
                if (!mis) pass_cnt <= pass_cnt == MAX ? pass_cnt : pass_cnt + 1'b1;
                else begin
                    fail_cnt <= fail_cnt == MAX ? fail_cnt : fail_cnt + 1'b1;
                    if (!fail_seen) begin
                        fail_seen <= 1'b1;
                        first_fail_idx <= pidx[LATENCY];
                    end
                end
            end
        end
    end
endmodule
